// File: rtl/mips_defs.sv
// mips_defs: shared MIPS opcode/funct encodings, register-file sizing and the
// decoded-operand record passed from operand fetch to the ALU.
package mips_defs;
   localparam int         NUM_REGS = 32;
   localparam int         REG_AW   = $clog2(NUM_REGS);
   localparam logic [4:0] LINK_REG = 5'd31;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   typedef struct packed {
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [31:0] operand_a;
      logic [31:0] operand_b;
      logic [31:0] store_data;
      logic [31:0] link_data;
      logic [4:0]  dest_reg;
      logic        reg_write;
      logic        illegal;
   } fetch_t;
endpackage

// File: rtl/register_file_32x32.sv
// register_file_32x32: 2-read/1-write register file with r0 hardwired to zero
// and write-through bypass so a same-cycle write is visible on the read ports.
// Ports: clk, reset (async, active-high); we/waddr/wdata write port;
//        raddr_a/rdata_a and raddr_b/rdata_b combinational read ports.
module register_file_32x32
   import mips_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [31:0]       rdata_a,
   output logic [31:0]       rdata_b
);
   logic [31:0] regs [NUM_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) regs <= '{default: '0};
      else if (we && waddr != '0) regs[waddr] <= wdata;
   end

   assign rdata_a = raddr_a == '0 ? '0 : (we && waddr == raddr_a) ? wdata : regs[raddr_a];
   assign rdata_b = raddr_b == '0 ? '0 : (we && waddr == raddr_b) ? wdata : regs[raddr_b];
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: MIPS decode/operand fetch; reads the owned register
// file, forms immediates/jump targets and registers ALU-ready operands behind
// a single-entry valid/ready pipeline register.
// Ports: clk, reset (async, active-high); in_valid/in_ready/instr/pc_plus4
//        upstream; flush; wb_en/wb_addr/wb_data writeback; out_valid/out_ready
//        plus opcode, funct, operand_a/b, store_data, link_data, dest_reg,
//        reg_write, illegal downstream.
module operand_fetch_stage
   import mips_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc_plus4,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] operand_a,
   output logic [31:0] operand_b,
   output logic [31:0] store_data,
   output logic [31:0] link_data,
   output logic [4:0]  dest_reg,
   output logic        reg_write,
   output logic        illegal
);
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val, simm, zimm, jump_target;
   logic        take;
   fetch_t      nxt, q;

   register_file_32x32 u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val)
   );

   assign op          = instr[31:26];
   assign fn          = instr[5:0];
   assign rs          = instr[25:21];
   assign rt          = instr[20:16];
   assign rd          = instr[15:11];
   assign simm        = {{16{instr[15]}}, instr[15:0]};
   assign zimm        = {16'h0000, instr[15:0]};
   assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign in_ready    = !out_valid || out_ready;
   assign take        = in_valid && in_ready && !flush;

   // Fields an instruction does not use stay 0 so the ALU sees clean values.
   always_comb begin
      nxt = '0;
      nxt.opcode = op;
      case (op)
         OP_LW: begin
            nxt.operand_a = rs_val + simm;
            nxt.dest_reg  = rt;
            nxt.reg_write = 1'b1;
         end
         OP_SW: begin
            nxt.operand_a  = rs_val + simm;
            nxt.store_data = rt_val;
         end
         OP_J: nxt.operand_a = jump_target;
         OP_JAL: begin
            nxt.operand_a = jump_target;
            nxt.dest_reg  = LINK_REG;
            nxt.reg_write = 1'b1;
            nxt.link_data = pc_plus4;
         end
         OP_BEQ, OP_BNE: begin
            nxt.operand_a = rs_val;
            nxt.operand_b = rt_val;
         end
         OP_XORI, OP_ADDI: begin
            nxt.operand_a = rs_val;
            nxt.operand_b = op == OP_XORI ? zimm : simm;
            nxt.dest_reg  = rt;
            nxt.reg_write = 1'b1;
         end
         OP_RTYPE: begin
            nxt.funct     = fn;
            nxt.operand_a = rs_val;
            if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) begin
               nxt.operand_b = rt_val;
               nxt.dest_reg  = rd;
               nxt.reg_write = 1'b1;
            end else if (fn != FN_JR) begin
               nxt.illegal = 1'b1;
            end
         end
         default: nxt.illegal = 1'b1;
      endcase
      // Unsupported encodings become an ADD NOP with zero operands.
      if (nxt.illegal) begin
         nxt = '0;
         nxt.opcode  = OP_RTYPE;
         nxt.funct   = FN_ADD;
         nxt.illegal = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         q         <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (take) begin
         out_valid <= 1'b1;
         q         <= nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign opcode     = q.opcode;
   assign funct      = q.funct;
   assign operand_a  = q.operand_a;
   assign operand_b  = q.operand_b;
   assign store_data = q.store_data;
   assign link_data  = q.link_data;
   assign dest_reg   = q.dest_reg;
   assign reg_write  = q.reg_write;
   assign illegal    = q.illegal;
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the ALU.
- Takes a 32-bit MIPS instruction word and PC+4.
- Reads the 32x32 register file, which it owns, and forms immediates and jump/address values.
- Registers opcode, funct, operand_a and operand_b in exactly the form the ALU expects, behind a single-entry valid/ready pipeline register. Writeback returns through the wb port.

Parameters:
- NUM_REGS, 32, register count; address width is log2(NUM_REGS) = 5.
- LINK_REG, 31, destination register for JAL.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  instr/pc_plus4 valid
- in_ready  out  1  stage can accept
- instr  in  32  instruction word
- pc_plus4  in  32  address of instr + 4
- flush  in  1  discard held entry and any same-cycle input
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  32  write data
- out_valid  out  1  output entry valid
- out_ready  in  1  ALU stage accepts
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]; forced 0 unless opcode = RTYPE
- operand_a  out  32  ALU operand A
- operand_b  out  32  ALU operand B
- store_data  out  32  rt value (SW)
- link_data  out  32  pc_plus4 (JAL)
- dest_reg  out  5  write-back register
- reg_write  out  1  instruction writes a register
- illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (asynchronous, active-high): out_valid=0; all data outputs 0; all registers 0.
- Register file:
  - r0 reads 0, and writes to r0 are ignored.
  - Writes occur on the clk edge when wb_en=1.
  - Read bypass: if wb_en and wb_addr==rs (or rt) and wb_addr!=0, the read returns wb_data in the same cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture when in_valid && in_ready; out_valid <= 1 next cycle.
  - If out_valid && out_ready && !(in_valid && in_ready), then out_valid <= 0.
  - Latency is 1 cycle. Throughput is 1/cycle while out_ready=1.
  - Held outputs are stable while out_valid && !out_ready.
- flush:
  - Next cycle, out_valid=0.
  - Same-cycle in_valid is dropped (in_ready may be 1; nothing captured).
  - flush overrides capture. Register-file writes still occur.
- Operand formation (captured values; simm = sign-extended instr[15:0], zimm = zero-extended instr[15:0]):
  - LW/SW: operand_a = rs + simm (32-bit wrap, no overflow flag), operand_b = 0. LW: dest = rt, reg_write = 1. SW: reg_write = 0, store_data = rt.
  - J: operand_a = {pc_plus4[31:28], instr[25:0], 2'b00}, reg_write = 0.
  - JAL: operand_a as for J; dest = LINK_REG, reg_write = 1, link_data = pc_plus4.
  - BEQ/BNE: operand_a = rs, operand_b = rt, reg_write = 0.
  - XORI: operand_a = rs, operand_b = zimm, dest = rt, reg_write = 1.
  - ADDI: operand_a = rs, operand_b = simm, dest = rt, reg_write = 1.
  - RTYPE ADD/SUB/SLT: operand_a = rs, operand_b = rt, dest = rd, reg_write = 1.
  - RTYPE JR: operand_a = rs, reg_write = 0.
  - Any other opcode, or RTYPE with another funct: illegal = 1, reg_write = 0, opcode/funct set to RTYPE/ADD, operands 0 (a NOP that is safe for the ALU).
- Operands are sampled at capture only. RAW hazards against instructions in flight are handled by the upstream hazard unit, which withholds in_valid.
- Reset asserted mid-transfer: entry lost, out_valid falls immediately (asynchronous).

Decomposition:
- Shared package mips_defs holds the opcode constants (LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, RTYPE), the funct constants (JR, ADD, SUB, SLT) and LINK_REG. The ALU uses the same package.
- One sub-module: register_file_32x32 (2 read ports, 1 write port, r0 hardwired, write-through bypass).
- Decode and operand muxing stay in this stage.

Test Plan:
- Preload r1=5 and r2=7 via wb. Issue ADD $3,$1,$2 (funct 100000) -> next cycle: out_valid=1, operand_a=5, operand_b=7, dest_reg=3, reg_write=1.
- r4=0x1000. Issue LW $5,-4($4) -> operand_a=0x00000FFC, dest_reg=5, reg_write=1. Issue XORI $6,$4,0xFFFF -> operand_b=0x0000FFFF.
- JAL target 0x0100000 with pc_plus4=0x40000004 -> operand_a=0x40400000, dest_reg=31, link_data=0x40000004.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Release -> the next instruction is captured on the following edge with no loss or duplication.
- Same cycle: wb_en=1, wb_addr=2, wb_data=0xDEAD, plus instr SUB $7,$2,$2 -> operand_a=operand_b=0xDEAD (bypass). Repeat with wb_addr=0 -> operands read 0.
- flush with in_valid=1 while holding an entry -> out_valid=0 next cycle, nothing captured. Opcode 0x3F -> illegal=1, reg_write=0. Assert reset mid-hold -> out_valid=0 immediately and r1 reads 0.
